// File: rtl/lbp_recog_ctrl_p.sv
// Top-level sequencer for the LBP face-recognition datapath: CLBP, a raster of HCU
// grids, then ID enrollment (train) or comparison (recognize), with watchdog and abort.
module lbp_recog_ctrl_p #(
  parameter int GRID_X  = 4,
  parameter int GRID_Y  = 4,
  parameter int GRID_W  = 4,
  parameter int ID_W    = 5,
  parameter int ADDR_W  = 8,
  parameter int MAX_IDS = 32,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              id_valid,
  input  logic [ID_W-1:0]   id,
  input  logic              abort,
  output logic [ADDR_W-1:0] id_addr,
  output logic [ID_W-1:0]   id_wdata,
  output logic              id_wen,
  output logic              lbp_enable,
  input  logic              lbp_finish,
  output logic              ram_clbp,
  input  logic [GRID_W-1:0] gridX_i,
  input  logic [GRID_W-1:0] gridY_i,
  output logic              hcu_enable,
  output logic [GRID_W-1:0] gridX_o,
  output logic [GRID_W-1:0] gridY_o,
  input  logic              hcu_finish,
  output logic              comparator_enable,
  input  logic              comparator_finish,
  output logic              ram_comp,
  output logic              busy,
  output logic              done,
  output logic [2:0]        error,
  output logic [ADDR_W-1:0] enroll_count,
  output logic              full
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LBP     = 3'd1;
  localparam logic [2:0] S_HCU_RUN = 3'd2;
  localparam logic [2:0] S_HCU_GAP = 3'd3;
  localparam logic [2:0] S_ID_WR   = 3'd4;
  localparam logic [2:0] S_COMP    = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd1;
  localparam logic [2:0] ERR_FULL     = 3'd2;
  localparam logic [2:0] ERR_EMPTY    = 3'd3;
  localparam logic [2:0] ERR_ABORT    = 3'd4;
  localparam logic [2:0] ERR_GRID     = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [2:0]        error_nxt;
  logic              mode_q, mode_nxt;
  logic [ID_W-1:0]   id_q, id_nxt;
  logic [GRID_W-1:0] grid_x, grid_y, grid_x_nxt, grid_y_nxt;
  logic [TO_W-1:0]   wd_cnt;
  logic              wd_expired;
  logic              wd_counting;
  logic              last_x, last_y;

  // wd_cnt is 0 on the first cycle of a state, so the TIMEOUT-th cycle is the last one allowed
  assign wd_expired  = (wd_cnt == TO_W'(TIMEOUT - 1));
  assign wd_counting = (state == S_LBP) || (state == S_HCU_RUN) || (state == S_COMP);
  assign last_x      = (grid_x == GRID_W'(GRID_X - 1));
  assign last_y      = (grid_y == GRID_W'(GRID_Y - 1));

  always_comb begin
    state_nxt  = state;
    error_nxt  = error;
    mode_nxt   = mode_q;
    id_nxt     = id_q;
    grid_x_nxt = grid_x;
    grid_y_nxt = grid_y;
    if (state != S_IDLE && abort) begin
      state_nxt = S_IDLE;
      error_nxt = ERR_ABORT;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (mode || id_valid)) begin
            mode_nxt = mode;
            id_nxt   = id;
            if (!mode && full) begin
              error_nxt = ERR_FULL;
            end else if (mode && enroll_count == '0) begin
              error_nxt = ERR_EMPTY;
            end else begin
              error_nxt = ERR_NONE;
              state_nxt = S_LBP;
            end
          end
        end
        S_LBP: begin
          if (lbp_finish) begin
            state_nxt  = S_HCU_RUN;
            grid_x_nxt = '0;
            grid_y_nxt = '0;
          end else if (wd_expired) begin
            state_nxt = S_IDLE;
            error_nxt = ERR_TIMEOUT;
          end
        end
        S_HCU_RUN: begin
          if (hcu_finish) begin
            if (gridX_i != grid_x || gridY_i != grid_y) begin
              state_nxt = S_IDLE;
              error_nxt = ERR_GRID;
            end else begin
              state_nxt = S_HCU_GAP;
            end
          end else if (wd_expired) begin
            state_nxt = S_IDLE;
            error_nxt = ERR_TIMEOUT;
          end
        end
        S_HCU_GAP: begin
          if (last_x && last_y) begin
            state_nxt = mode_q ? S_COMP : S_ID_WR;
          end else if (last_x) begin
            grid_x_nxt = '0;
            grid_y_nxt = grid_y + GRID_W'(1);
            state_nxt  = S_HCU_RUN;
          end else begin
            grid_x_nxt = grid_x + GRID_W'(1);
            state_nxt  = S_HCU_RUN;
          end
        end
        S_ID_WR: state_nxt = S_FIN;
        S_COMP: begin
          if (comparator_finish) begin
            state_nxt = S_FIN;
          end else if (wd_expired) begin
            state_nxt = S_IDLE;
            error_nxt = ERR_TIMEOUT;
          end
        end
        S_FIN:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // The enrollment write is unconditional once in ID_WR, so an abort there still counts it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      error        <= ERR_NONE;
      mode_q       <= 1'b0;
      id_q         <= '0;
      grid_x       <= '0;
      grid_y       <= '0;
      wd_cnt       <= '0;
      enroll_count <= '0;
    end else begin
      state  <= state_nxt;
      error  <= error_nxt;
      mode_q <= mode_nxt;
      id_q   <= id_nxt;
      grid_x <= grid_x_nxt;
      grid_y <= grid_y_nxt;
      if (state == S_ID_WR)
        enroll_count <= enroll_count + ADDR_W'(1);
      if (state_nxt != state)
        wd_cnt <= '0;
      else if (wd_counting)
        wd_cnt <= wd_cnt + TO_W'(1);
    end
  end

  assign busy              = (state != S_IDLE);
  assign lbp_enable        = (state == S_LBP);
  assign ram_clbp          = (state == S_LBP);
  assign hcu_enable        = (state == S_HCU_RUN);
  assign comparator_enable = (state == S_COMP);
  assign ram_comp          = (state == S_COMP);
  assign id_wen            = (state == S_ID_WR);
  assign id_addr           = id_wen ? enroll_count : '0;
  assign id_wdata          = id_wen ? id_q : '0;
  assign done              = (state == S_FIN) && !abort;
  assign gridX_o           = grid_x;
  assign gridY_o           = grid_y;
  assign full              = ({1'b0, enroll_count} == (ADDR_W + 1)'(MAX_IDS));

endmodule

// File: tb/tb_lbp_recog_ctrl_p.sv
// Scoreboard bench for lbp_recog_ctrl_p: expected grids, ID writes and done pulses are
// queued as jobs are driven and retired by a monitor when the DUT produces them.
module tb_lbp_recog_ctrl_p;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       first;
  } grid_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [4:0] data;
  } wen_t;

  logic       clk, rst;
  logic       start, mode, id_valid, abort;
  logic [4:0] id;
  logic [7:0] id_addr;
  logic [4:0] id_wdata;
  logic       id_wen, lbp_enable, lbp_finish, ram_clbp;
  logic [3:0] gridX_i, gridY_i, gridX_o, gridY_o;
  logic       hcu_enable, hcu_finish, comparator_enable, comparator_finish, ram_comp;
  logic       busy, done, full;
  logic [2:0] error;
  logic [7:0] enroll_count;

  logic       start_b, lbp_finish_b, hcu_finish_b;
  logic [3:0] gridX_i_b, gridY_i_b, gridX_o_b, gridY_o_b;
  logic [7:0] id_addr_b, enroll_count_b;
  logic [4:0] id_wdata_b;
  logic       id_wen_b, lbp_enable_b, ram_clbp_b, hcu_enable_b, comparator_enable_b;
  logic       ram_comp_b, busy_b, done_b, full_b;
  logic [2:0] error_b;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    count_model = 0;
  grid_t grid_q[$];
  wen_t  wen_q[$];
  int    done_q[$];
  grid_t grid_e;
  wen_t  wen_e;
  int    done_e;
  logic  hcu_prev = 1'b0;
  int    low_len  = 0;
  logic  hcu_prev_b = 1'b0;
  int    runs_b  = 0;
  int    dones_b = 0;

  lbp_recog_ctrl_p dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .id_valid(id_valid), .id(id),
    .abort(abort), .id_addr(id_addr), .id_wdata(id_wdata), .id_wen(id_wen),
    .lbp_enable(lbp_enable), .lbp_finish(lbp_finish), .ram_clbp(ram_clbp),
    .gridX_i(gridX_i), .gridY_i(gridY_i), .hcu_enable(hcu_enable),
    .gridX_o(gridX_o), .gridY_o(gridY_o), .hcu_finish(hcu_finish),
    .comparator_enable(comparator_enable), .comparator_finish(comparator_finish),
    .ram_comp(ram_comp), .busy(busy), .done(done), .error(error),
    .enroll_count(enroll_count), .full(full)
  );

  lbp_recog_ctrl_p #(.GRID_X(2), .GRID_Y(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(1'b0), .id_valid(1'b1), .id(5'd3),
    .abort(1'b0), .id_addr(id_addr_b), .id_wdata(id_wdata_b), .id_wen(id_wen_b),
    .lbp_enable(lbp_enable_b), .lbp_finish(lbp_finish_b), .ram_clbp(ram_clbp_b),
    .gridX_i(gridX_i_b), .gridY_i(gridY_i_b), .hcu_enable(hcu_enable_b),
    .gridX_o(gridX_o_b), .gridY_o(gridY_o_b), .hcu_finish(hcu_finish_b),
    .comparator_enable(comparator_enable_b), .comparator_finish(1'b0),
    .ram_comp(ram_comp_b), .busy(busy_b), .done(done_b), .error(error_b),
    .enroll_count(enroll_count_b), .full(full_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Retires queued expectations as the DUT produces grid starts, ID writes and done pulses
  always @(negedge clk) begin
    if (hcu_enable && !hcu_prev) begin
      if (grid_q.size() == 0) begin
        checkOutput("grid_extra", 1, 0);
      end else begin
        grid_e = grid_q.pop_front();
        checkOutput("grid_xy", {gridX_o, gridY_o}, {grid_e.x, grid_e.y});
        if (!grid_e.first) checkOutput("hcu_gap", low_len, 1);
      end
    end
    low_len  <= hcu_enable ? 0 : low_len + 1;
    hcu_prev <= hcu_enable;
    if (id_wen) begin
      if (wen_q.size() == 0) begin
        checkOutput("wen_extra", 1, 0);
      end else begin
        wen_e = wen_q.pop_front();
        checkOutput("wen_addr", id_addr, wen_e.addr);
        checkOutput("wen_data", id_wdata, wen_e.data);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checkOutput("done_extra", 1, 0);
      end else begin
        done_e = done_q.pop_front();
        checkOutput("done_err", error, 0);
      end
    end
    if (hcu_enable_b && !hcu_prev_b) runs_b <= runs_b + 1;
    hcu_prev_b <= hcu_enable_b;
    if (done_b) dones_b <= dones_b + 1;
  end

  task automatic applyStimulus(input logic m, input logic v, input logic [4:0] i);
    @(negedge clk);
    start = 1'b1; mode = m; id_valid = v; id = i;
    @(negedge clk);
    start = 1'b0; id_valid = 1'b0;
  endtask

  task automatic run_hcu(input int n, input int bad, input int abort_at);
    int k;
    logic [3:0] gx, gy;
    for (int g = 0; g < n; g++) begin
      gx = 4'(g % 4);
      gy = 4'(g / 4);
      k = 0;
      while (hcu_enable !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      if (hcu_enable !== 1'b1) begin checkOutput("hcu_wait", 0, 1); return; end
      if (g == abort_at) begin
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("abort_err", error, 4);
        checkOutput("abort_idle", {busy, hcu_enable}, 0);
        return;
      end
      repeat (2) @(negedge clk);
      hcu_finish = 1'b1;
      gridX_i = (g == bad) ? gx + 4'd1 : gx;
      gridY_i = gy;
      @(negedge clk);
      hcu_finish = 1'b0;
      if (g == bad) begin
        checkOutput("mm_err", error, 5);
        checkOutput("mm_idle", {busy, hcu_enable}, 0);
        return;
      end
    end
  endtask

  task automatic push_grids(input int n);
    grid_t e;
    for (int g = 0; g < n; g++) begin
      e.x = 4'(g % 4); e.y = 4'(g / 4); e.first = (g == 0);
      grid_q.push_back(e);
    end
  endtask

  task automatic run_job(input logic m, input logic [4:0] idv, input int lbp_dly, input bit rst_mid);
    int   k;
    wen_t w;
    push_grids(16);
    if (!m) begin w.addr = 8'(count_model); w.data = idv; wen_q.push_back(w); end
    if (!rst_mid) done_q.push_back(1);
    applyStimulus(m, 1'b1, idv);
    checkOutput("lbp_start", {lbp_enable, ram_clbp, busy}, 3'b111);
    repeat (lbp_dly - 1) @(negedge clk);
    lbp_finish = 1'b1;
    @(negedge clk);
    lbp_finish = 1'b0;
    checkOutput("lbp_drop", {lbp_enable, ram_clbp, hcu_enable, error}, 6'b001000);
    run_hcu(16, -1, -1);
    if (m) begin
      k = 0;
      while (comparator_enable !== 1'b1 && k < 10) begin @(negedge clk); k++; end
      checkOutput("comp_en", {comparator_enable, ram_comp}, 2'b11);
      if (rst_mid) begin
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_out", {busy, comparator_enable, ram_comp, done, id_wen, lbp_enable, hcu_enable}, 0);
        checkOutput("rst_count", {enroll_count, full, error}, 0);
        checkOutput("rst_grid", {gridX_o, gridY_o, id_addr, id_wdata}, 0);
        @(negedge clk);
        rst = 1'b1;
        count_model = 0;
        return;
      end
      repeat (3) @(negedge clk);
      checkOutput("comp_hold", {comparator_enable, ram_comp}, 2'b11);
      comparator_finish = 1'b1;
      @(negedge clk);
      comparator_finish = 1'b0;
      checkOutput("comp_drop", {comparator_enable, ram_comp}, 0);
    end
    k = 0;
    while (done !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    checkOutput("done_seen", done, 1);
    @(negedge clk);
    if (!m) count_model++;
    checkOutput("job_idle", {busy, error}, 0);
    checkOutput("enroll_cnt", enroll_count, count_model);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] stuck");
  end

  initial begin
    int  k;
    logic seen;
    rst = 1'b0; start = 0; mode = 0; id_valid = 0; id = 0; abort = 0;
    lbp_finish = 0; hcu_finish = 0; comparator_finish = 0; gridX_i = 0; gridY_i = 0;
    start_b = 0; lbp_finish_b = 0; hcu_finish_b = 0; gridX_i_b = 0; gridY_i_b = 0;
    #3;
    checkOutput("reset_ctl", {busy, done, id_wen, lbp_enable, ram_clbp, hcu_enable, comparator_enable, ram_comp}, 0);
    checkOutput("reset_val", {error, enroll_count, full, gridX_o, gridY_o, id_addr, id_wdata}, 0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b1, 1'b1, 5'd0);
    checkOutput("empty_err", error, 3);
    seen = busy;
    repeat (3) begin @(negedge clk); seen |= busy; end
    checkOutput("empty_busy", seen, 0);
    applyStimulus(1'b0, 1'b0, 5'd4);
    checkOutput("novalid_ign", {busy, error}, 3);

    run_job(1'b0, 5'd5, 10, 1'b0);
    run_job(1'b1, 5'd0, 4, 1'b0);

    applyStimulus(1'b0, 1'b1, 5'd7);
    k = 0;
    while (lbp_enable === 1'b1 && k < 1100) begin k++; @(negedge clk); end
    checkOutput("to_cycles", k, 1023);
    checkOutput("to_err", {error, busy, lbp_enable}, 5'b00100);
    checkOutput("to_cnt", enroll_count, count_model);

    run_job(1'b0, 5'd9, 1023, 1'b0);

    push_grids(2);
    applyStimulus(1'b0, 1'b1, 5'd11);
    lbp_finish = 1'b1; @(negedge clk); lbp_finish = 1'b0;
    run_hcu(16, 1, -1);
    repeat (4) @(negedge clk);
    checkOutput("mm_cnt", enroll_count, count_model);

    push_grids(7);
    applyStimulus(1'b0, 1'b1, 5'd12);
    lbp_finish = 1'b1; @(negedge clk); lbp_finish = 1'b0;
    run_hcu(16, -1, 6);

    while (count_model < 32) run_job(1'b0, 5'(count_model + 1), 2, 1'b0);
    checkOutput("full_flag", full, 1);

    applyStimulus(1'b0, 1'b1, 5'd1);
    checkOutput("full_err", {error, busy}, 4'b0100);
    seen = lbp_enable;
    repeat (3) begin @(negedge clk); seen |= lbp_enable; end
    checkOutput("full_nolbp", seen, 0);

    run_job(1'b1, 5'd0, 3, 1'b1);

    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    repeat (2) @(negedge clk);
    lbp_finish_b = 1'b1; @(negedge clk); lbp_finish_b = 1'b0;
    for (int g = 0; g < 8; g++) begin
      k = 0;
      while (hcu_enable_b !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      if (hcu_enable_b !== 1'b1) break;
      repeat (2) @(negedge clk);
      hcu_finish_b = 1'b1; gridX_i_b = 4'(g % 2); gridY_i_b = 4'(g / 2);
      @(negedge clk);
      hcu_finish_b = 1'b0;
    end
    checkOutput("b_runs", runs_b, 6);
    checkOutput("b_done", dones_b, 1);
    checkOutput("b_state", {enroll_count_b, error_b, busy_b}, 12'h010);

    repeat (3) @(negedge clk);
    checkOutput("q_grid", grid_q.size(), 0);
    checkOutput("q_wen", wen_q.size(), 0);
    checkOutput("q_done", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
